// File: rtl/int_rf_pkg.sv
// Shared types and sizes for the integer register-file write-back arbiter.
package int_rf_pkg;

  localparam int NUM_WB_REQ = 4;
  localparam int REG_ADDR_W = 5;
  localparam int ROB_IDX_W  = 4;
  localparam int DATA_W     = 32;
  localparam int PTR_W      = $clog2(NUM_WB_REQ);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wn;
    logic [DATA_W-1:0]     data;
    logic [ROB_IDX_W-1:0]  rob;
  } wb_req_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/int_rf_wb_arbiter_rr_pick2.sv
// Combinational two-grant round-robin picker; a second candidate writing the
// same register as the first is skipped so both ports never target one register.
module rr_pick2
  import int_rf_pkg::*;
(
  input  wb_req_t [NUM_WB_REQ-1:0] req_i,
  input  logic    [PTR_W-1:0]      ptr_i,
  output logic    [NUM_WB_REQ-1:0] grant_o,
  output logic                     a_vld_o,
  output logic    [PTR_W-1:0]      a_idx_o,
  output logic                     b_vld_o,
  output logic    [PTR_W-1:0]      b_idx_o,
  output logic                     conflict_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    a_vld_o    = 1'b0;
    a_idx_o    = '0;
    b_vld_o    = 1'b0;
    b_idx_o    = '0;
    conflict_o = 1'b0;
    grant_o    = '0;
    idx        = '0;
    for (int k = 0; k < NUM_WB_REQ; k++) begin
      idx = ptr_i + PTR_W'(k);
      if (req_i[idx].valid) begin
        if (!a_vld_o) begin
          a_vld_o = 1'b1;
          a_idx_o = idx;
        end else if (!b_vld_o) begin
          if (req_i[idx].wn == req_i[a_idx_o].wn) begin
            conflict_o = 1'b1;
          end else begin
            b_vld_o = 1'b1;
            b_idx_o = idx;
          end
        end
      end
    end
    if (a_vld_o) grant_o[a_idx_o] = 1'b1;
    if (b_vld_o) grant_o[b_idx_o] = 1'b1;
  end

endmodule

// File: rtl/int_rf_wb_arbiter.sv
// Write-back arbiter: up to four result producers onto two register-file write ports.
// Optional statistics counters are enabled with INT_RF_WB_ARB_STATS_EN.
module int_rf_wb_arbiter
  import int_rf_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WB_REQ-1:0]            req_valid,
  input  logic [NUM_WB_REQ*REG_ADDR_W-1:0] req_wn,
  input  logic [NUM_WB_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_WB_REQ*ROB_IDX_W-1:0]  req_rob,
  output logic [NUM_WB_REQ-1:0]            req_ready,
  input  logic                             flush,
  output logic                             wea,
  output logic [REG_ADDR_W-1:0]            wna,
  output logic [DATA_W-1:0]                dataina,
  output logic [ROB_IDX_W-1:0]             ROB_index_wta,
  output logic                             web,
  output logic [REG_ADDR_W-1:0]            wnb,
  output logic [DATA_W-1:0]                datainb,
  output logic [ROB_IDX_W-1:0]             ROB_index_wtb
`ifdef INT_RF_WB_ARB_STATS_EN
  ,
  output logic [31:0]                      stat_grants,
  output logic [31:0]                      stat_conflicts
`endif
);

  wb_req_t [NUM_WB_REQ-1:0] reqs;
  logic    [NUM_WB_REQ-1:0] grant;
  logic                     a_vld, b_vld, conflict;
  logic    [PTR_W-1:0]      a_idx, b_idx;
  logic                     arb_en, a_go, b_go;
  logic    [PTR_W-1:0]      ptr_q, ptr_d;

  logic                  wea_q, web_q;
  logic [REG_ADDR_W-1:0] wna_q, wnb_q;
  logic [DATA_W-1:0]     dataa_q, datab_q;
  logic [ROB_IDX_W-1:0]  roba_q, robb_q;

  always_comb begin
    for (int i = 0; i < NUM_WB_REQ; i++) begin
      reqs[i].valid = req_valid[i];
      reqs[i].wn    = req_wn[i*REG_ADDR_W +: REG_ADDR_W];
      reqs[i].data  = req_data[i*DATA_W +: DATA_W];
      reqs[i].rob   = req_rob[i*ROB_IDX_W +: ROB_IDX_W];
    end
  end

  rr_pick2 u_pick (
    .req_i      (reqs),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .a_vld_o    (a_vld),
    .a_idx_o    (a_idx),
    .b_vld_o    (b_vld),
    .b_idx_o    (b_idx),
    .conflict_o (conflict)
  );

  // Flush and reset both suppress every handshake in the current cycle.
  assign arb_en    = ~flush & ~rst;
  assign req_ready = grant & {NUM_WB_REQ{arb_en}};
  assign a_go      = a_vld & arb_en;
  assign b_go      = b_vld & arb_en;

  always_comb begin
    ptr_d = ptr_q;
    if (flush)     ptr_d = '0;
    else if (b_go) ptr_d = b_idx + PTR_W'(1);
    else if (a_go) ptr_d = a_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      wea_q   <= 1'b0;
      web_q   <= 1'b0;
      wna_q   <= '0;
      wnb_q   <= '0;
      dataa_q <= '0;
      datab_q <= '0;
      roba_q  <= '0;
      robb_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      // Register x0 is accepted but never written.
      wea_q <= a_go && (reqs[a_idx].wn != '0);
      web_q <= b_go && (reqs[b_idx].wn != '0);
      if (a_go) begin
        wna_q   <= reqs[a_idx].wn;
        dataa_q <= reqs[a_idx].data;
        roba_q  <= reqs[a_idx].rob;
      end
      if (b_go) begin
        wnb_q   <= reqs[b_idx].wn;
        datab_q <= reqs[b_idx].data;
        robb_q  <= reqs[b_idx].rob;
      end
    end
  end

  assign wea           = wea_q;
  assign wna           = wna_q;
  assign dataina       = dataa_q;
  assign ROB_index_wta = roba_q;
  assign web           = web_q;
  assign wnb           = wnb_q;
  assign datainb       = datab_q;
  assign ROB_index_wtb = robb_q;

`ifdef INT_RF_WB_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_conflicts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants_q    <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_grants_q    <= stat_grants_q + 32'(popcount4(req_ready));
      stat_conflicts_q <= stat_conflicts_q + 32'(conflict & arb_en);
    end
  end

  assign stat_grants    = stat_grants_q;
  assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: doc/int_rf_wb_arbiter.md
INT_RF_WB_ARBITER -- requirements
Module: int_rf_wb_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req_valid  in  4  per-requester result valid (requester i = bit i).
REQ-004 SHALL have port: req_wn  in  20  destination register; requester i at [5i+4:5i].
REQ-005 SHALL have port: req_data  in  128  result data; requester i at [32i+31:32i].
REQ-006 SHALL have port: req_rob  in  16  producing ROB index; requester i at [4i+3:4i].
REQ-007 SHALL have port: req_ready  out  4  combinational grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port: flush  in  1  pipeline flush; suppresses all grants in the current cycle.
REQ-009 SHALL have ports: wea, wna[4:0], dataina[31:0], ROB_index_wta[3:0]  out  register-file write port A, registered.
REQ-010 SHALL have ports: web, wnb[4:0], datainb[31:0], ROB_index_wtb[3:0]  out  register-file write port B, registered.

Function
REQ-011 SHALL keep a 2-bit round-robin pointer ptr; the scan order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 SHALL grant at most two requesters per cycle: the first valid requester in scan order goes to port A, and the next valid one goes to port B.
REQ-013 SHALL NOT grant the second candidate if its req_wn equals the port-A candidate's req_wn; that candidate waits, and the scan continues to the next valid requester for port B.
REQ-014 SHALL accept a request with req_wn==0 (ready high, counts as a grant) but SHALL drive the corresponding write enable low for it.
REQ-015 SHALL register each granted request onto its port the cycle after the grant; latency from handshake to wea/web is exactly 1 cycle.
REQ-016 SHALL drive wea/web low in any cycle following a cycle with no grant on that port; wn, data and ROB index hold their previous values.
REQ-017 SHALL set ptr to (index of last granted requester)+1 mod 4 after any grant, and leave ptr unchanged when there is no grant.
REQ-018 SHALL, while flush=1, drive req_ready=0, clear wea/web on the next edge, and load ptr=0.
REQ-019 SHALL grant any continuously valid requester within 3 cycles, provided no same-wn conflict persists.
REQ-020 SHALL NOT assert req_ready for an invalid requester.

Reset
REQ-021 SHALL on rst=1 immediately force: wea=0, web=0, wna=wnb=0, dataina=datainb=0, ROB_index_wta=ROB_index_wtb=0, ptr=0, and all statistic counters=0.
REQ-022 SHALL hold req_ready=0 while rst=1; a request in flight at reset is dropped, not replayed.

Configuration
REQ-023 SHALL, when INT_RF_WB_ARB_STATS_EN is defined, add these outputs:
  - stat_grants[31:0]: increments by the number of grants each cycle, wrapping.
  - stat_conflicts[31:0]: increments by 1 in each cycle where REQ-013 deferred a candidate, wrapping.
REQ-024 SHALL, when INT_RF_WB_ARB_STATS_EN is undefined, omit those ports and counters entirely, with no other behavioural change.

Structure
REQ-025 SHALL take NUM_WB_REQ=4, REG_ADDR_W=5, ROB_IDX_W=4, DATA_W=32 and a wb_req_t struct (valid, wn, data, rob) from shared package int_rf_pkg.
REQ-026 SHALL place the two-grant round-robin selection with wn-conflict skip in combinational sub-module rr_pick2; the top level holds ptr, the output registers and the counters.

Verification
REQ-027 SHALL cover: ptr=0, valid=4'b1111, wn=1,2,3,4 -> ready=4'b0011; next cycle wea=1 wna=1, web=1 wnb=2; ptr becomes 2.
REQ-028 SHALL cover: valid=4'b0101, wn0=7, wn2=7, ptr=0 -> ready=4'b0001, wna=7 next cycle, web=0; the following cycle ready=4'b0100.
REQ-029 SHALL cover: valid=4'b1000, wn3=0, data=32'hDEAD -> ready=4'b1000; next cycle wea=0, web=0.
REQ-030 SHALL cover: valid=4'b1111 with flush=1 -> ready=0, next cycle wea=web=0, ptr=0.
REQ-031 SHALL cover: rst pulsed mid-cycle while wea=1 -> wea=0 and all outputs 0 before the next clk edge.
REQ-032 SHALL cover: all four requesters valid for 8 cycles with distinct wn -> each requester granted exactly 4 times; with INT_RF_WB_ARB_STATS_EN defined, stat_grants=16.
